// File: rtl/uart_tx_frame_gen.sv
// rtl/uart_tx_frame_gen.sv - UART transmit frame generator
//
// Serialises one frame per accepted word: start bit, DATA_WIDTH data bits
// (LSB first), optional parity bit, then 1 or 2 stop bits. Every bit lasts
// PRESCALE+1 clock cycles. Frame configuration is latched at accept time.
//
// Optional feature macro: UART_TX_BREAK_EN (adds i_break_req and a break
// sequence: line low for 2 x frame-length bit periods, then one stop period).
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         synchronous active-high reset
//   i_break_req   (UART_TX_BREAK_EN only) request a break from IDLE
//   i_p_data      parallel data word
//   i_data_valid  source offers i_p_data
//   i_par_en      insert parity bit
//   i_par_typ     0 even parity, 1 odd parity
//   i_stop2       two stop bits when high
//   i_prescale    bit period minus one, in clock cycles
//   o_ready       word accepted when i_data_valid & o_ready
//   o_tx_out      serial line, idles high
//   o_busy        high while a frame (or break) is on the line
module uart_tx_frame_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
`ifdef UART_TX_BREAK_EN
  input  logic                   i_break_req,
`endif
  input  logic [DATA_WIDTH-1:0]  i_p_data,
  input  logic                   i_data_valid,
  input  logic                   i_par_en,
  input  logic                   i_par_typ,
  input  logic                   i_stop2,
  input  logic [PRESC_WIDTH-1:0] i_prescale,
  output logic                   o_ready,
  output logic                   o_tx_out,
  output logic                   o_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_BRK_STOP
  } state_t;

  // Bit counter must reach 2 x longest frame (2 x 13) during a break.
  localparam logic [4:0]             LAST_DATA = 5'(DATA_WIDTH - 1);
  localparam logic [PRESC_WIDTH-1:0] ONE_P     = PRESC_WIDTH'(1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PRESC_WIDTH-1:0]  r_clk_cnt;
  logic [PRESC_WIDTH-1:0]  r_presc;
  logic [4:0]              r_bit_cnt;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic                    r_par;
  logic                    r_par_en;
  logic                    r_stop2;
  logic                    w_bit_end;
  logic                    w_accept;
`ifdef UART_TX_BREAK_EN
  logic [4:0]              r_brk_last;
  logic                    w_brk_start;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bit_end   = (r_clk_cnt == r_presc);
    w_accept    = 1'b0;
    o_tx_out    = 1'b1;
    o_busy      = 1'b1;
    o_ready     = 1'b0;
`ifdef UART_TX_BREAK_EN
    w_brk_start = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        o_busy  = 1'b0;
        o_ready = 1'b1;
`ifdef UART_TX_BREAK_EN
        // A pending break wins over data, so data is refused this cycle.
        if (i_break_req) begin
          o_ready     = 1'b0;
          w_brk_start = 1'b1;
          w_state_nxt = S_BREAK;
        end else
`endif
        if (i_data_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        o_tx_out = 1'b0;
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        o_tx_out = r_shift[0];
        if (w_bit_end && (r_bit_cnt == LAST_DATA))
          w_state_nxt = r_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        o_tx_out = r_par;
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        // Final cycle of the last stop bit doubles as an accept slot so
        // back-to-back frames have no idle gap.
        if (w_bit_end && (r_bit_cnt == {4'b0, r_stop2})) begin
          o_ready = 1'b1;
          if (i_data_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        o_tx_out = 1'b0;
        if (w_bit_end && (r_bit_cnt == r_brk_last)) w_state_nxt = S_BRK_STOP;
      end
      S_BRK_STOP: begin
        if (w_bit_end) w_state_nxt = S_IDLE;
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_presc    <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
`ifdef UART_TX_BREAK_EN
      r_brk_last <= '0;
`endif
    end else if (w_accept) begin
      r_shift   <= i_p_data;
      r_par     <= i_par_typ ? ~^i_p_data : ^i_p_data;
      r_par_en  <= i_par_en;
      r_stop2   <= i_stop2;
      r_presc   <= i_prescale;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
    end
`ifdef UART_TX_BREAK_EN
    else if (w_brk_start) begin
      // Last index of 2 x (2 + DATA_WIDTH + par + stop2) low bit periods.
      r_brk_last <= 5'(2 * (2 + DATA_WIDTH) - 1)
                    + {3'b0, i_par_en, 1'b0} + {3'b0, i_stop2, 1'b0};
      r_presc    <= i_prescale;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
    end
`endif
    else if (r_state != S_IDLE) begin
      if (w_bit_end) begin
        r_clk_cnt <= '0;
        if (r_state == S_DATA) r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
        // Counter restarts whenever the state changes, so it indexes bits
        // within the current state only.
        if (w_state_nxt != r_state) r_bit_cnt <= '0;
        else                        r_bit_cnt <= r_bit_cnt + 5'd1;
      end else begin
        r_clk_cnt <= r_clk_cnt + ONE_P;
      end
    end
  end

endmodule
